// File: rtl/operand_entry_ctrl.sv
// Keypad operand-entry controller: collects BCD digits with backspace/clear/enter,
// auto-commits when full, then converts to binary one digit per cycle.
module operand_entry_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned VAL_W    = 14,
    parameter int unsigned CNT_W    = $clog2(N_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [CNT_W-1:0]      digit_count,
    output logic                  display_en,
    output logic [VAL_W-1:0]      operand,
    output logic                  operand_valid,
    output logic                  busy
);

    localparam int unsigned DW = 4 * N_DIGITS;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPress   = 3'd1,
        StHold    = 3'd2,
        StConvert = 3'd3,
        StDone    = 3'd4
    } state_e;

    state_e             state_q;
    logic [3:0]         code_q;
    logic               commit_q;
    logic [VAL_W-1:0]   acc_q;
    logic [CNT_W-1:0]   idx_q;

    logic [DW-1:0]      sel_digits;
    logic [VAL_W-1:0]   acc_next;
    logic               count_full;
    logic               count_zero;

    always_comb begin
        sel_digits = digits >> {idx_q, 2'b00};
        acc_next   = acc_q * VAL_W'(10) + VAL_W'(sel_digits[3:0]);
        count_full = (digit_count == CNT_W'(N_DIGITS));
        count_zero = (digit_count == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            code_q        <= '0;
            commit_q      <= 1'b0;
            acc_q         <= '0;
            idx_q         <= '0;
            digits        <= '0;
            digit_count   <= '0;
            display_en    <= 1'b0;
            operand       <= '0;
            operand_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            display_en    <= 1'b0;
            operand_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (key_valid) begin
                        code_q  <= key_code;
                        state_q <= StPress;
                    end
                end
                StPress: begin
                    if (code_q <= 4'd9) begin
                        if (!count_full) begin
                            digits      <= (digits << 4) | DW'(code_q);
                            digit_count <= digit_count + CNT_W'(1);
                            display_en  <= 1'b1;
                        end
                    end else if (code_q == 4'hB) begin
                        if (!count_zero) begin
                            digits      <= digits >> 4;
                            digit_count <= digit_count - CNT_W'(1);
                            display_en  <= 1'b1;
                        end
                    end else if (code_q == 4'hC) begin
                        digits      <= '0;
                        digit_count <= '0;
                        display_en  <= 1'b1;
                    end else if (code_q == 4'hA) begin
                        if (!count_zero) commit_q <= 1'b1;
                    end
                    state_q <= StHold;
                end
                StHold: begin
                    if (!key_valid) begin
                        if (commit_q || count_full) begin
                            acc_q   <= '0;
                            idx_q   <= digit_count - CNT_W'(1);
                            busy    <= 1'b1;
                            state_q <= StConvert;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StConvert: begin
                    acc_q <= acc_next;
                    // Last digit: the DONE-cycle outputs are registered on this edge.
                    if (idx_q == '0) begin
                        operand       <= acc_next;
                        operand_valid <= 1'b1;
                        digits        <= '0;
                        digit_count   <= '0;
                        display_en    <= 1'b1;
                        commit_q      <= 1'b0;
                        state_q       <= StDone;
                    end else begin
                        idx_q <= idx_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= key_valid ? StHold : StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl: default 4-digit instance plus a 5-digit/17-bit one.
module tb_operand_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        kv_a, kv_b;
    logic [3:0]  code_a, code_b;

    logic [15:0] digits_a;
    logic [2:0]  count_a;
    logic        de_a, ov_a, busy_a;
    logic [13:0] operand_a;

    logic [19:0] digits_b;
    logic [2:0]  count_b;
    logic        de_b, ov_b, busy_b;
    logic [16:0] operand_b;

    int errors = 0;
    int checks = 0;
    int de_cnt = 0;
    int ov_cnt = 0;
    int bz_cnt = 0;
    int lat;
    int base_de, base_ov, base_bz;

    always #5 clk = ~clk;

    operand_entry_ctrl u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (kv_a),
        .key_code      (code_a),
        .digits        (digits_a),
        .digit_count   (count_a),
        .display_en    (de_a),
        .operand       (operand_a),
        .operand_valid (ov_a),
        .busy          (busy_a)
    );

    operand_entry_ctrl #(
        .N_DIGITS (5),
        .VAL_W    (17)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (kv_b),
        .key_code      (code_b),
        .digits        (digits_b),
        .digit_count   (count_b),
        .display_en    (de_b),
        .operand       (operand_b),
        .operand_valid (ov_b),
        .busy          (busy_b)
    );

    // Pulse counters; sampled at posedge so they see the value held through the prior cycle.
    always @(posedge clk) begin
        if (de_a) de_cnt++;
        if (ov_a) ov_cnt++;
        if (busy_a) bz_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit b, input logic [3:0] code, input int hold);
        @(negedge clk);
        if (b) begin
            kv_b   = 1'b1;
            code_b = code;
        end else begin
            kv_a   = 1'b1;
            code_a = code;
        end
        repeat (hold) @(negedge clk);
        if (b) kv_b = 1'b0;
        else   kv_a = 1'b0;
    endtask

    // Negedges from the call until operand_valid is seen; -1 if it never arrives.
    task automatic wait_ov(input bit b, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b ? ov_b : ov_a) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        kv_a   = 1'b0;
        kv_b   = 1'b0;
        code_a = 4'h0;
        code_b = 4'h0;
        idle(2);
        check("rst_digits", 32'(digits_a), 32'h0);
        check("rst_count", 32'(count_a), 0);
        check("rst_operand", 32'(operand_a), 0);
        check("rst_de", 32'(de_a), 0);
        check("rst_ov", 32'(ov_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        reset = 1'b1;
        idle(2);

        // 1,2,3 then Enter
        base_de = de_cnt;
        press(0, 4'd1, 3); idle(2);
        press(0, 4'd2, 3); idle(2);
        press(0, 4'd3, 3); idle(2);
        check("t1_digits", 32'(digits_a), 32'h0123);
        check("t1_count", 32'(count_a), 3);
        check("t1_de_pulses", 32'(de_cnt - base_de), 3);
        base_ov = ov_cnt;
        press(0, 4'hA, 3);
        wait_ov(0, lat);
        check("t1_latency", 32'(lat), 4);
        check("t1_operand", 32'(operand_a), 123);
        check("t1_de_with_ov", 32'(de_a), 1);
        check("t1_busy_done", 32'(busy_a), 1);
        idle(3);
        check("t1_digits_clr", 32'(digits_a), 0);
        check("t1_count_clr", 32'(count_a), 0);
        check("t1_ov_pulses", 32'(ov_cnt - base_ov), 1);
        check("t1_busy_off", 32'(busy_a), 0);

        // 9,8,7,6 auto-commit
        press(0, 4'd9, 3); idle(2);
        press(0, 4'd8, 3); idle(2);
        press(0, 4'd7, 3); idle(2);
        press(0, 4'd6, 3);
        wait_ov(0, lat);
        check("t2_latency", 32'(lat), 5);
        check("t2_operand", 32'(operand_a), 32'h2694);
        idle(3);
        check("t2_count", 32'(count_a), 0);
        check("t2_digits", 32'(digits_a), 0);

        // 4,5,BS,7,Enter
        press(0, 4'd4, 3); idle(2);
        press(0, 4'd5, 3); idle(2);
        check("t3_digits45", 32'(digits_a), 32'h0045);
        press(0, 4'hB, 3); idle(2);
        check("t3_digits_bs", 32'(digits_a), 32'h0004);
        press(0, 4'd7, 3); idle(2);
        check("t3_digits47", 32'(digits_a), 32'h0047);
        check("t3_count", 32'(count_a), 2);
        press(0, 4'hA, 3);
        wait_ov(0, lat);
        check("t3_latency", 32'(lat), 3);
        check("t3_operand", 32'(operand_a), 47);
        idle(3);
        base_de = de_cnt;
        press(0, 4'hB, 3); idle(3);
        check("t3_bs_empty_de", 32'(de_cnt - base_de), 0);
        check("t3_bs_empty_cnt", 32'(count_a), 0);

        // Enter at count 0, Clear, ignored code
        base_ov = ov_cnt;
        base_bz = bz_cnt;
        press(0, 4'hA, 3); idle(6);
        check("t4_enter0_ov", 32'(ov_cnt - base_ov), 0);
        check("t4_enter0_busy", 32'(bz_cnt - base_bz), 0);
        press(0, 4'd3, 3); idle(2);
        press(0, 4'd8, 3); idle(2);
        check("t4_digits38", 32'(digits_a), 32'h0038);
        base_de = de_cnt;
        press(0, 4'hC, 3); idle(3);
        check("t4_clr_digits", 32'(digits_a), 0);
        check("t4_clr_count", 32'(count_a), 0);
        check("t4_clr_de", 32'(de_cnt - base_de), 1);
        press(0, 4'd3, 3); idle(2);
        base_de = de_cnt;
        press(0, 4'hE, 3); idle(3);
        check("t4_keyE_digits", 32'(digits_a), 32'h0003);
        check("t4_keyE_de", 32'(de_cnt - base_de), 0);
        press(0, 4'hC, 3); idle(2);

        // Long hold, then key held across conversion
        press(0, 4'd5, 20); idle(2);
        check("t5_hold_count", 32'(count_a), 1);
        check("t5_hold_digits", 32'(digits_a), 32'h0005);
        press(0, 4'd1, 3); idle(2);
        base_ov = ov_cnt;
        press(0, 4'hA, 3);
        @(negedge clk);
        check("t5_busy_conv", 32'(busy_a), 1);
        kv_a   = 1'b1;
        code_a = 4'd2;
        wait_ov(0, lat);
        check("t5_latency", 32'(lat), 2);
        check("t5_operand", 32'(operand_a), 51);
        idle(5);
        kv_a = 1'b0;
        idle(3);
        check("t5_count_after", 32'(count_a), 0);
        check("t5_digits_after", 32'(digits_a), 0);
        check("t5_ov_pulses", 32'(ov_cnt - base_ov), 1);

        // Async reset mid-conversion
        press(0, 4'd1, 3); idle(2);
        press(0, 4'd2, 3); idle(2);
        press(0, 4'd3, 3); idle(2);
        press(0, 4'd4, 3);
        @(negedge clk);
        check("t6_busy_pre", 32'(busy_a), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_busy", 32'(busy_a), 0);
        check("t6_operand", 32'(operand_a), 0);
        check("t6_digits", 32'(digits_a), 0);
        check("t6_count", 32'(count_a), 0);
        check("t6_ov", 32'(ov_a), 0);
        check("t6_de", 32'(de_a), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        base_ov = ov_cnt;
        base_bz = bz_cnt;
        press(0, 4'hA, 3); idle(6);
        check("t6_enter0_ov", 32'(ov_cnt - base_ov), 0);
        check("t6_enter0_busy", 32'(bz_cnt - base_bz), 0);

        // Wide instance: 99999
        for (int k = 0; k < 4; k++) begin
            press(1, 4'd9, 3);
            idle(2);
        end
        check("t7_digits", 32'(digits_b), 32'h09999);
        check("t7_count", 32'(count_b), 4);
        press(1, 4'd9, 3);
        wait_ov(1, lat);
        check("t7_latency", 32'(lat), 6);
        check("t7_operand", 32'(operand_b), 99999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
- Parametrised keypad operand-entry controller for the calculator datapath; successor to the fixed 4-digit number-entry FSM.
- Collects up to N_DIGITS decimal key presses into a BCD display register and supports backspace, clear and enter.
- Auto-commits when the register is full.
- On commit, converts the BCD digits to binary sequentially (one digit per cycle) and hands the operand to the ALU stage with a one-cycle valid pulse.

Parameters:
- N_DIGITS, 4, maximum digits per operand (>=1).
- VAL_W, 14, binary operand width; must satisfy 2^VAL_W > 10^N_DIGITS-1.
- CNT_W, $clog2(N_DIGITS+1), digit counter width (derived).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_valid  input  1  level, high while a key is held; already synchronised and debounced upstream.
- key_code  input  4  key held: 0-9 digit, 4'hA enter, 4'hB backspace, 4'hC clear, 4'hD-4'hF ignored.
- digits  output  4*N_DIGITS  BCD display digits, nibble 0 = most recent digit.
- digit_count  output  CNT_W  number of digits currently entered.
- display_en  output  1  one-cycle pulse; digits/digit_count changed this cycle.
- operand  output  VAL_W  last committed binary operand; held until the next commit.
- operand_valid  output  1  one-cycle pulse when operand updates.
- busy  output  1  high in CONVERT and DONE.

Behaviour:
- Reset (reset=0, async): state IDLE; digits, digit_count, operand, accumulator and index = 0; display_en=operand_valid=busy=0. Reset mid-operation aborts any conversion immediately.
- All outputs are registered.
- States: IDLE, PRESS, HOLD, CONVERT, DONE.
- IDLE: key_valid=1 -> capture key_code and go to PRESS. Otherwise stay in IDLE.
- PRESS (1 cycle), executes the action; results and display_en are visible in the next cycle:
  - Digit with count<N: digits <= {digits[4N-5:0], code}; count+1; display_en.
  - Digit with count==N: no change, no pulse.
  - Backspace with count>0: digits shift right one nibble, top nibble=0; count-1; display_en.
  - Backspace with count==0: no change, no pulse.
  - Clear: digits=0, count=0; display_en always pulses.
  - Enter with count>0: set commit flag. Enter with count==0: ignored.
  - Codes D-F: ignored.
  - Always go to HOLD.
- HOLD: wait for key_valid=0; a held key produces exactly one action. On release:
  - Commit flag set, or count==N -> CONVERT (auto-commit).
  - Otherwise -> IDLE.
- CONVERT:
  - acc starts at 0, idx = count-1.
  - Each cycle: acc <= acc*10 + digits[idx]; idx decrements.
  - Takes exactly digit_count cycles, then go to DONE.
  - acc arithmetic is modulo 2^VAL_W.
  - key_valid ignored.
- DONE (1 cycle):
  - operand <= acc; operand_valid=1.
  - digits=0, count=0, display_en=1, commit flag cleared.
  - Next state: HOLD if key_valid=1 (a key pressed during conversion is never acted on), else IDLE.
- Latency: release at cycle R (HOLD samples key_valid=0) -> CONVERT in cycles R+1..R+count -> operand_valid in cycle R+count+1.
- Concurrency: display_en and operand_valid never both high except in the DONE cycle.
- Recovery: an illegal state encoding recovers to IDLE on the next clock.

Test Plan:
- Keys 1,2,3 then Enter (each held 3 cycles, released 2) -> after the 3rd digit: digits=16'h0123, digit_count=3, 3 display_en pulses. operand=123 with a single operand_valid pulse exactly 4 cycles after Enter release; digits=0, count=0.
- Keys 9,8,7,6 with no Enter -> auto-commit on the 4th release; operand=9876 (14'h2694); a 5th digit is never stored.
- Key 4, key 5, Backspace, key 7, Enter -> digits 0x0047 before Enter, operand=47. A Backspace at count 0 produces no display_en pulse.
- Enter at count 0 -> no busy, no operand_valid. Keys 3, 8, then Clear -> digits=0, count=0, display_en pulse. Key 0xE -> no effect.
- Key 5 held 20 cycles -> exactly one digit stored. Key 2 pressed and held during CONVERT -> DONE goes to HOLD, and 2 is not stored after commit.
- reset driven low mid-CONVERT (between clock edges) -> all outputs 0 immediately. After reset release, the next Enter at count 0 is ignored; VAL_W=17 with N_DIGITS=5 and keys 99999 -> operand=99999.
